// File: rtl/if_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_stage_pkg
// Description : Shared constants and types for the instruction-fetch stage:
//               next-PC select encodings, exception vectors, bubble
//               instruction and the IF/ID register layout.
// Revision    : 1.0 - initial release
// ============================================================================
package if_stage_pkg;

  // Next-PC select encodings driven by ID/EX control
  localparam logic [2:0] PCSRC_SEQ   = 3'b000;
  localparam logic [2:0] PCSRC_BR    = 3'b001;
  localparam logic [2:0] PCSRC_J     = 3'b010;
  localparam logic [2:0] PCSRC_JR    = 3'b011;
  localparam logic [2:0] PCSRC_ILLOP = 3'b100;
  localparam logic [2:0] PCSRC_XADR  = 3'b101;

  // Exception entry points and the all-zero bubble instruction
  localparam logic [31:0] ILLOP_VEC = 32'h8000_0004;
  localparam logic [31:0] XADR_VEC  = 32'h8000_0008;
  localparam logic [31:0] NOP_INST  = 32'h0000_0000;

  // IF/ID pipeline register contents
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc_plus4;
    logic        valid;
  } ifid_t;

  // Sequential increment keeps the supervisor bit (bit 31) fixed and lets
  // the lower 31 bits wrap within their half of the address space.
  function automatic logic [31:0] pc_inc4(input logic [31:0] pc);
    return {pc[31], pc[30:0] + 31'd4};
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : if_stage_if
// Description : Bundle of hazard-control, redirect, instruction-memory and
//               IF/ID signals around the fetch stage. The slave modport is
//               the fetch stage; the master modport is its environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface if_stage_if;

  logic        stall;
  logic        if_flush;
  logic [2:0]  pc_src;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] jr_target;
  logic [31:0] imem_inst;
  logic [31:0] pc;
  logic [31:0] ifid_inst;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;

  modport master (
    output stall, if_flush, pc_src, branch_taken,
    output branch_target, jump_target, jr_target, imem_inst,
    input  pc, ifid_inst, ifid_pc_plus4, ifid_valid
  );

  modport slave (
    input  stall, if_flush, pc_src, branch_taken,
    input  branch_target, jump_target, jr_target, imem_inst,
    output pc, ifid_inst, ifid_pc_plus4, ifid_valid
  );

endinterface
`default_nettype wire

// File: rtl/if_stage_pc_next_sel.sv
`default_nettype none
// ============================================================================
// Module      : pc_next_sel
// Description : Combinational next-PC selector. Produces the candidate next
//               PC and flags whether it is a redirect (a change of control
//               flow that squashes the wrong-path fetch).
//               Optional feature macro: EXC_VECTOR_EN enables the ILLOP and
//               XADR exception vectors on pc_src 100/101.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_next_sel
  import if_stage_pkg::*;
(
  input  logic [2:0]  i_pc_src,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_target,
  input  logic [31:0] i_jump_target,
  input  logic [31:0] i_jr_target,
  input  logic [31:0] i_pc_plus4,
  output logic [31:0] o_next_pc,
  output logic        o_redirect
);

  // Decode pc_src; anything that is not a taken transfer falls through to PC+4
  always_comb begin
    o_next_pc  = i_pc_plus4;
    o_redirect = 1'b0;
    case (i_pc_src)
      PCSRC_BR: begin
        if (i_branch_taken) begin
          o_next_pc  = i_branch_target;
          o_redirect = 1'b1;
        end
      end
      PCSRC_J: begin
        o_next_pc  = i_jump_target;
        o_redirect = 1'b1;
      end
      PCSRC_JR: begin
        o_next_pc  = i_jr_target;
        o_redirect = 1'b1;
      end
`ifdef EXC_VECTOR_EN
      PCSRC_ILLOP: begin
        o_next_pc  = ILLOP_VEC;
        o_redirect = 1'b1;
      end
      PCSRC_XADR: begin
        o_next_pc  = XADR_VEC;
        o_redirect = 1'b1;
      end
`else
      PCSRC_ILLOP, PCSRC_XADR: begin
        o_next_pc  = i_pc_plus4;
        o_redirect = 1'b0;
      end
`endif
      default: begin
        o_next_pc  = i_pc_plus4;
        o_redirect = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_stage
// Description : Instruction-fetch stage. Holds the PC and the IF/ID pipeline
//               register; applies stall, flush and redirect from the hazard
//               unit and ID/EX control. PC is purely registered.
//               Optional feature macro: EXC_VECTOR_EN (exception vectors).
// Revision    : 1.0 - initial release
// ============================================================================
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  if_stage_if.slave   bus
);

  logic [31:0] r_pc;
  ifid_t       r_ifid;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_next_pc;
  logic        w_redirect;

  assign w_pc_plus4 = pc_inc4(r_pc);

  pc_next_sel u_pc_next_sel (
    .i_pc_src        (bus.pc_src),
    .i_branch_taken  (bus.branch_taken),
    .i_branch_target (bus.branch_target),
    .i_jump_target   (bus.jump_target),
    .i_jr_target     (bus.jr_target),
    .i_pc_plus4      (w_pc_plus4),
    .o_next_pc       (w_next_pc),
    .o_redirect      (w_redirect)
  );

  // PC: a redirect overrides stall so a taken transfer is never lost
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (w_redirect) begin
      r_pc <= w_next_pc;
    end else if (!bus.stall) begin
      r_pc <= w_pc_plus4;
    end
  end

  // IF/ID: flush or redirect squashes the current fetch, stall holds it
  always_ff @(posedge clk) begin
    if (reset || bus.if_flush || w_redirect) begin
      r_ifid <= '{inst: NOP_INST, pc_plus4: 32'h0, valid: 1'b0};
    end else if (!bus.stall) begin
      r_ifid <= '{inst: bus.imem_inst, pc_plus4: w_pc_plus4, valid: 1'b1};
    end
  end

  assign bus.pc            = r_pc;
  assign bus.ifid_inst     = r_ifid.inst;
  assign bus.ifid_pc_plus4 = r_ifid.pc_plus4;
  assign bus.ifid_valid    = r_ifid.valid;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_stage
// Description : Self-checking bench for if_stage. Instruction memory returns
//               address+1. Expected PC / IF/ID state is pushed per clock and
//               compared against captured DUT state.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] pp4;
    logic        valid;
  } obs_t;

  logic clk = 1'b0;
  logic reset;

  if_stage_if bus ();

  if_stage #(.RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.imem_inst = bus.pc + 32'd1;

  obs_t sb_exp[$];
  obs_t sb_obs[$];
  int   checks = 0;
  int   errors = 0;

  logic [31:0] m_pc, m_inst, m_pp4;
  logic        m_valid;

  // Push the expected post-edge state, clock once, capture the DUT state
  task automatic tick();
    logic [31:0] pp4, tgt;
    logic        redir;
    pp4   = {m_pc[31], m_pc[30:0] + 31'd4};
    redir = 1'b0;
    tgt   = pp4;
    case (bus.pc_src)
      3'b001: if (bus.branch_taken) begin redir = 1'b1; tgt = bus.branch_target; end
      3'b010: begin redir = 1'b1; tgt = bus.jump_target; end
      3'b011: begin redir = 1'b1; tgt = bus.jr_target; end
`ifdef EXC_VECTOR_EN
      3'b100: begin redir = 1'b1; tgt = 32'h8000_0004; end
      3'b101: begin redir = 1'b1; tgt = 32'h8000_0008; end
`endif
      default: ;
    endcase
    if (reset) begin
      m_pc = RESET_PC; m_inst = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0;
    end else begin
      if (bus.if_flush || redir) begin
        m_inst = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0;
      end else if (!bus.stall) begin
        m_inst = m_pc + 32'd1; m_pp4 = pp4; m_valid = 1'b1;
      end
      if (redir)           m_pc = tgt;
      else if (!bus.stall) m_pc = pp4;
    end
    sb_exp.push_back({m_pc, m_inst, m_pp4, m_valid});
    @(posedge clk);
    #1;
    sb_obs.push_back({bus.pc, bus.ifid_inst, bus.ifid_pc_plus4, bus.ifid_valid});
  endtask

  task automatic set_idle();
    bus.stall = 1'b0; bus.if_flush = 1'b0; bus.pc_src = 3'b000;
    bus.branch_taken = 1'b0; bus.branch_target = 32'h0;
    bus.jump_target = 32'h0; bus.jr_target = 32'h0;
  endtask

  task automatic test_reset();
    set_idle();
    reset = 1'b1;
    bus.stall = 1'b1; bus.pc_src = 3'b011; bus.jr_target = 32'hDEAD_BEEF;
    tick(); tick();
    checks++;
    if (bus.pc !== 32'h8000_0000 || bus.ifid_inst !== 32'h0 ||
        bus.ifid_pc_plus4 !== 32'h0 || bus.ifid_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: pc=%h inst=%h pp4=%h v=%b required pc=80000000 inst=0 pp4=0 v=0",
               bus.pc, bus.ifid_inst, bus.ifid_pc_plus4, bus.ifid_valid);
    end
    while (sb_exp.size() > 0) begin
      obs_t e, o;
      e = sb_exp.pop_front(); o = sb_obs.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset_sb: got %h required %h", o, e);
      end
    end
  endtask

  task automatic test_sequential();
    set_idle();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.pc !== 32'h8000_0000 + 32'(4 * i)) begin
        errors++;
        $display("FAIL seq_pc%0d: got %h required %h", i, bus.pc, 32'h8000_0000 + 32'(4 * i));
      end
      tick();
      if (i == 0) begin
        checks++;
        if (bus.ifid_valid !== 1'b1 || bus.ifid_inst !== 32'h8000_0001) begin
          errors++;
          $display("FAIL seq_first_fetch: v=%b inst=%h required v=1 inst=80000001",
                   bus.ifid_valid, bus.ifid_inst);
        end
      end
    end
    while (sb_exp.size() > 0) begin
      obs_t e, o;
      e = sb_exp.pop_front(); o = sb_obs.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL seq_sb: got %h required %h", o, e);
      end
    end
  endtask

  task automatic test_stall();
    set_idle();
    bus.stall = 1'b1;
    tick(); tick();
    checks++;
    if (bus.pc !== 32'h8000_0010 || bus.ifid_inst !== 32'h8000_000D || bus.ifid_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_hold: pc=%h inst=%h v=%b required pc=80000010 inst=8000000d v=1",
               bus.pc, bus.ifid_inst, bus.ifid_valid);
    end
    bus.stall = 1'b0;
    tick();
    checks++;
    if (bus.pc !== 32'h8000_0014 || bus.ifid_inst !== 32'h8000_0011) begin
      errors++;
      $display("FAIL stall_release: pc=%h inst=%h required pc=80000014 inst=80000011",
               bus.pc, bus.ifid_inst);
    end
    tick();
    checks++;
    if (bus.ifid_inst !== 32'h8000_0015) begin
      errors++;
      $display("FAIL stall_no_dup: inst=%h required 80000015", bus.ifid_inst);
    end
    while (sb_exp.size() > 0) begin
      obs_t e, o;
      e = sb_exp.pop_front(); o = sb_obs.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL stall_sb: got %h required %h", o, e);
      end
    end
  endtask

  task automatic test_stall_flush();
    set_idle();
    bus.pc_src = 3'b010; bus.jump_target = 32'h8000_0020;
    tick();
    set_idle();
    bus.stall = 1'b1; bus.if_flush = 1'b1;
    tick();
    checks++;
    if (bus.pc !== 32'h8000_0020 || bus.ifid_valid !== 1'b0 || bus.ifid_inst !== 32'h0) begin
      errors++;
      $display("FAIL stflush_bubble: pc=%h inst=%h v=%b required pc=80000020 inst=0 v=0",
               bus.pc, bus.ifid_inst, bus.ifid_valid);
    end
    set_idle();
    tick();
    checks++;
    if (bus.ifid_inst !== 32'h8000_0021 || bus.ifid_valid !== 1'b1 || bus.pc !== 32'h8000_0024) begin
      errors++;
      $display("FAIL stflush_refetch: pc=%h inst=%h v=%b required pc=80000024 inst=80000021 v=1",
               bus.pc, bus.ifid_inst, bus.ifid_valid);
    end
    while (sb_exp.size() > 0) begin
      obs_t e, o;
      e = sb_exp.pop_front(); o = sb_obs.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL stflush_sb: got %h required %h", o, e);
      end
    end
  endtask

  task automatic test_branch();
    set_idle();
    bus.stall = 1'b1; bus.pc_src = 3'b001; bus.branch_taken = 1'b1;
    bus.branch_target = 32'h8000_0100;
    tick();
    checks++;
    if (bus.pc !== 32'h8000_0100 || bus.ifid_valid !== 1'b0) begin
      errors++;
      $display("FAIL branch_taken: pc=%h v=%b required pc=80000100 v=0", bus.pc, bus.ifid_valid);
    end
    set_idle();
    tick();
    bus.stall = 1'b1; bus.pc_src = 3'b001; bus.branch_taken = 1'b0;
    bus.branch_target = 32'h8000_0200;
    tick();
    checks++;
    if (bus.pc !== 32'h8000_0104 || bus.ifid_inst !== 32'h8000_0101 || bus.ifid_valid !== 1'b1) begin
      errors++;
      $display("FAIL branch_not_taken: pc=%h inst=%h v=%b required pc=80000104 inst=80000101 v=1",
               bus.pc, bus.ifid_inst, bus.ifid_valid);
    end
    while (sb_exp.size() > 0) begin
      obs_t e, o;
      e = sb_exp.pop_front(); o = sb_obs.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL branch_sb: got %h required %h", o, e);
      end
    end
  endtask

  task automatic test_exc_wrap();
    logic [31:0] want;
    set_idle();
    bus.pc_src = 3'b100;
    tick();
`ifdef EXC_VECTOR_EN
    want = 32'h8000_0004;
`else
    want = 32'h8000_0108;
`endif
    checks++;
    if (bus.pc !== want) begin
      errors++;
      $display("FAIL exc_illop: pc=%h required %h", bus.pc, want);
    end
    bus.pc_src = 3'b101;
    tick();
    set_idle();
    bus.pc_src = 3'b010; bus.jump_target = 32'h7FFF_FFFC;
    tick();
    set_idle();
    tick();
    checks++;
    if (bus.pc !== 32'h0000_0000 || bus.ifid_pc_plus4 !== 32'h0 || bus.ifid_inst !== 32'h7FFF_FFFD) begin
      errors++;
      $display("FAIL wrap_low: pc=%h pp4=%h inst=%h required pc=0 pp4=0 inst=7ffffffd",
               bus.pc, bus.ifid_pc_plus4, bus.ifid_inst);
    end
    bus.pc_src = 3'b011; bus.jr_target = 32'hFFFF_FFFC;
    tick();
    set_idle();
    tick();
    checks++;
    if (bus.pc !== 32'h8000_0000) begin
      errors++;
      $display("FAIL wrap_high: pc=%h required 80000000", bus.pc);
    end
    while (sb_exp.size() > 0) begin
      obs_t e, o;
      e = sb_exp.pop_front(); o = sb_obs.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL excwrap_sb: got %h required %h", o, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    set_idle();
    bus.pc_src = 3'b010; bus.jump_target = 32'h0000_4000;
    tick();
    bus.pc_src = 3'b011; bus.jr_target = 32'h0000_5000;
    tick();
    checks++;
    if (bus.pc !== 32'h0000_5000 || bus.ifid_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_last_wins: pc=%h v=%b required pc=00005000 v=0", bus.pc, bus.ifid_valid);
    end
    bus.pc_src = 3'b001; bus.branch_taken = 1'b1; bus.branch_target = 32'h0000_6000;
    bus.if_flush = 1'b1;
    tick();
    set_idle();
    tick();
    checks++;
    if (bus.pc !== 32'h0000_6004 || bus.ifid_inst !== 32'h0000_6001) begin
      errors++;
      $display("FAIL b2b_resume: pc=%h inst=%h required pc=00006004 inst=00006001",
               bus.pc, bus.ifid_inst);
    end
    while (sb_exp.size() > 0) begin
      obs_t e, o;
      e = sb_exp.pop_front(); o = sb_obs.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL b2b_sb: got %h required %h", o, e);
      end
    end
  endtask

  task automatic test_reset_mid_redirect();
    set_idle();
    bus.pc_src = 3'b011; bus.jr_target = 32'h0000_1234; bus.stall = 1'b1;
    reset = 1'b1;
    tick();
    checks++;
    if (bus.pc !== RESET_PC || bus.ifid_inst !== 32'h0 ||
        bus.ifid_pc_plus4 !== 32'h0 || bus.ifid_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: pc=%h inst=%h pp4=%h v=%b required pc=80000000 inst=0 pp4=0 v=0",
               bus.pc, bus.ifid_inst, bus.ifid_pc_plus4, bus.ifid_valid);
    end
    reset = 1'b0;
    set_idle();
    tick();
    checks++;
    if (bus.ifid_inst !== 32'h8000_0001 || bus.ifid_pc_plus4 !== 32'h8000_0004 || bus.ifid_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_first_fetch: inst=%h pp4=%h v=%b required inst=80000001 pp4=80000004 v=1",
               bus.ifid_inst, bus.ifid_pc_plus4, bus.ifid_valid);
    end
    while (sb_exp.size() > 0) begin
      obs_t e, o;
      e = sb_exp.pop_front(); o = sb_obs.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL rstmid_sb: got %h required %h", o, e);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      reset            = ($urandom_range(0, 15) == 0);
      bus.stall        = ($urandom_range(0, 3) == 0);
      bus.if_flush     = ($urandom_range(0, 3) == 0);
      bus.pc_src       = 3'($urandom_range(0, 7));
      bus.branch_taken = 1'($urandom_range(0, 1));
      bus.branch_target = $urandom & 32'hFFFF_FFFC;
      bus.jump_target   = $urandom & 32'hFFFF_FFFC;
      bus.jr_target     = $urandom;
      tick();
    end
    reset = 1'b0;
    while (sb_exp.size() > 0) begin
      obs_t e, o;
      e = sb_exp.pop_front(); o = sb_obs.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL random_sb: got %h required %h", o, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_stall_flush();
    test_branch();
    test_exc_wrap();
    test_back_to_back();
    test_reset_mid_redirect();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000, PC value loaded by reset.
REQ-002 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port stall  input  1  from hazard unit; 1 = hold PC (no new fetch).
REQ-005 SHALL have port if_flush  input  1  from hazard unit; 1 = load bubble (all zeros) into IF/ID.
REQ-006 SHALL have port pc_src  input  3  next-PC select from ID/EX control.
REQ-007 SHALL have port branch_taken  input  1  branch comparison result, qualifies pc_src=001.
REQ-008 SHALL have port branch_target  input  32  precomputed branch target.
REQ-009 SHALL have port jump_target  input  32  precomputed J/JAL target.
REQ-010 SHALL have port jr_target  input  32  register value for JR/JALR.
REQ-011 SHALL have port imem_inst  input  32  combinational instruction-memory read data for address pc.
REQ-012 SHALL have port pc  output  32  current fetch address, drives instruction memory.
REQ-013 SHALL have port ifid_inst  output  32  registered instruction to ID.
REQ-014 SHALL have port ifid_pc_plus4  output  32  registered PC+4 of that instruction.
REQ-015 SHALL have port ifid_valid  output  1  1 = ifid_inst is a real fetched instruction, 0 = bubble.

Function
REQ-016 pc_plus4 SHALL be {pc[31], pc[30:0] + 31'd4}; bit 31 (supervisor bit) never changes through sequential increment; carry out of bit 30 discarded (wrap to 0 within the half).
REQ-017 next-PC selection SHALL be: 000 pc_plus4; 001 branch_target if branch_taken else pc_plus4; 010 jump_target; 011 jr_target; 100/101 per REQ-028; 110/111 pc_plus4.
REQ-018 A redirect SHALL be any pc_src other than 000, excluding 001 with branch_taken=0, excluding 110/111, and excluding 100/101 when EXC_VECTOR_EN is undefined.
REQ-019 PC update each edge: redirect -> PC loads selected target (redirect wins over stall); else stall=1 -> PC holds; else PC loads pc_plus4.
REQ-020 IF/ID update each edge, priority order: if_flush=1 -> ifid_inst=0, ifid_pc_plus4=0, ifid_valid=0; else redirect -> same bubble (wrong-path instruction squashed); else stall=1 -> IF/ID holds all three fields; else load imem_inst, pc_plus4, ifid_valid=1.
REQ-021 Latency: instruction at address A SHALL appear on ifid_inst exactly one edge after pc==A with no stall, flush or redirect.
REQ-022 stall=1 and if_flush=1 together SHALL hold PC and insert one bubble; the held PC is re-fetched on the next unstalled cycle, so no instruction is lost or duplicated.
REQ-023 Back-to-back redirects SHALL each take effect on their own edge; the last one wins.
REQ-024 No combinational path SHALL exist from any input to pc; imem_inst SHALL reach only IF/ID.

Reset
REQ-025 On a clock edge with reset=1: pc=RESET_PC, ifid_inst=0, ifid_pc_plus4=0, ifid_valid=0, regardless of all other inputs.
REQ-026 Reset asserted mid-stall or mid-redirect SHALL discard the pending action; the first fetch after deassertion is from RESET_PC.
REQ-027 The first edge after reset deassertion with no stall SHALL load IF/ID from address RESET_PC.

Configuration
REQ-028 Macro EXC_VECTOR_EN: when defined, pc_src 100 SHALL select ILLOP vector 32'h8000_0004 and 101 SHALL select XADR vector 32'h8000_0008, both as redirects; when undefined, 100/101 SHALL behave as pc_plus4 and are not redirects.

Structure
REQ-029 A shared package SHALL hold pc_src encodings (PCSRC_SEQ, PCSRC_BR, PCSRC_J, PCSRC_JR, PCSRC_ILLOP, PCSRC_XADR), vector constants ILLOP_VEC/XADR_VEC and the bubble constant NOP_INST=32'h0.
REQ-030 Next-PC selection SHALL be a combinational sub-module pc_next_sel; PC and IF/ID registers stay in if_stage.

Verification
REQ-031 Reset then 4 free-running cycles, imem returns A+1 -> pc 8000_0000, 8000_0004, 8000_0008, 8000_000C; ifid_valid rises on the first edge after reset deassertion.
REQ-032 stall=1 for 2 cycles at pc=8000_0010, if_flush=0 -> pc holds 8000_0010, IF/ID holds prior instruction; after release IF/ID receives inst@8000_0010 exactly once.
REQ-033 stall=1 and if_flush=1 for 1 cycle at pc=8000_0020 -> ifid_valid=0, ifid_inst=0; next cycle fetches 8000_0020.
REQ-034 pc_src=001, branch_taken=1, branch_target=8000_0100, with stall=1 -> pc=8000_0100 next edge, IF/ID bubble; repeat with branch_taken=0 -> pc holds (stall), no bubble.
REQ-035 pc_src=100 -> pc=8000_0004 when EXC_VECTOR_EN is defined; pc=pc_plus4 when undefined; pc=7FFF_FFFC sequential -> 0000_0000 with bit 31 cleared (no carry into bit 31).
REQ-036 reset=1 asserted during pc_src=011 with jr_target=0000_1234 -> pc=RESET_PC, all IF/ID fields zero.
